// File: rtl/multicycle_core.sv
// Multi-cycle RV32I subset core: FETCH -> DECODE -> EXEC -> (MEM) -> WB, ecall parks in HALT.
// Optional macro MULTICYCLE_CORE_BRANCH_EN adds beq/bne; without it opcode 1100011 retires as a no-op.
module multicycle_core #(
    parameter int IMEM_AW = 5,
    parameter int DMEM_AW = 5
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               dmem_we,
    input  logic [31:0]        dmem_rdata,
    output logic               halted,
    output logic [31:0]        retired
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state, state_next;

    logic [IMEM_AW-1:0] pc, pc_next;
    logic [31:0]        ir, rs1_val, rs2_val, alu_res, alu_out, operand_b;
    logic [31:0]        regs [32];
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic               alu_ok, writes_rd;

    assign opcode     = ir[6:0];
    assign funct3     = ir[14:12];
    assign rd         = ir[11:7];
    assign imem_addr  = pc;
    assign dmem_addr  = alu_res[DMEM_AW+1:2];
    assign dmem_wdata = rs2_val;
    assign writes_rd  = ((opcode == OP_R || opcode == OP_I) && alu_ok) || opcode == OP_LOAD;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: state_next = (imem_rdata[6:0] == OP_SYSTEM) ? HALT : EXEC;
            EXEC:   state_next = (opcode == OP_LOAD || opcode == OP_STORE) ? MEM : WB;
            MEM: begin
                state_next = WB;
                dmem_we    = (opcode == OP_STORE);
            end
            WB:     state_next = FETCH;
            HALT:   halted = 1'b1;
            default: state_next = FETCH;
        endcase
    end

    // Immediate selection by format; unsupported funct3 values clear alu_ok so they retire without a write.
    always_comb begin
        operand_b = rs2_val;
        if (opcode == OP_I || opcode == OP_LOAD)
            operand_b = {{20{ir[31]}}, ir[31:20]};
        else if (opcode == OP_STORE)
            operand_b = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        alu_out = rs1_val + operand_b;
        alu_ok  = 1'b1;
        if (opcode == OP_R || opcode == OP_I) begin
            case (funct3)
                3'b000:  alu_out = (opcode == OP_R && ir[30]) ? rs1_val - operand_b : rs1_val + operand_b;
                3'b111:  alu_out = rs1_val & operand_b;
                3'b110:  alu_out = rs1_val | operand_b;
                3'b100:  alu_out = rs1_val ^ operand_b;
                3'b010:  alu_out = {31'd0, $signed(rs1_val) < $signed(operand_b)};
                default: alu_ok = 1'b0;
            endcase
        end
    end

`ifdef MULTICYCLE_CORE_BRANCH_EN
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    logic        branch_cond, branch_taken;
    logic [31:0] branch_off;
    logic        unused_bits;

    // Byte offset converted to a word offset, since PC counts words.
    assign branch_off  = $signed({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}) >>> 2;
    assign branch_cond = (opcode == OP_BRANCH) &&
                         ((funct3 == 3'b000 && rs1_val == rs2_val) ||
                          (funct3 == 3'b001 && rs1_val != rs2_val));
    assign pc_next     = branch_taken ? pc + branch_off[IMEM_AW-1:0] : pc + 1'b1;
    assign unused_bits = ^{alu_res[31:DMEM_AW+2], alu_res[1:0], ir[19:15], branch_off[31:IMEM_AW]};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)              branch_taken <= 1'b0;
        else if (state == EXEC) branch_taken <= branch_cond;
    end
`else
    logic unused_bits;

    assign pc_next     = pc + 1'b1;
    assign unused_bits = ^{alu_res[31:DMEM_AW+2], alu_res[1:0], ir[19:15]};
`endif

    // Architectural state; only WB commits, so a reset before WB discards the instruction.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            rs1_val <= '0;
            rs2_val <= '0;
            alu_res <= '0;
            retired <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                DECODE: begin
                    ir      <= imem_rdata;
                    rs1_val <= regs[imem_rdata[19:15]];
                    rs2_val <= regs[imem_rdata[24:20]];
                end
                EXEC: alu_res <= alu_out;
                WB: begin
                    if (writes_rd && rd != 5'd0)
                        regs[rd] <= (opcode == OP_LOAD) ? dmem_rdata : alu_res;
                    pc      <= pc_next;
                    retired <= retired + 32'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Testbench for multicycle_core: table vectors, directed multi-cycle sequences and random programs vs an ISA model.
// Honours MULTICYCLE_CORE_BRANCH_EN for the branch expectations.
module tb_multicycle_core;
    logic        clock = 1'b0;
    logic        reset, s_reset;
    logic [4:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_rdata, dmem_wdata, retired;
    logic        dmem_we, halted;
    logic [1:0]  s_imem_addr;
    logic [4:0]  s_dmem_addr;
    logic [31:0] s_imem_rdata, s_dmem_rdata, s_dmem_wdata, s_retired;
    logic        s_dmem_we, s_halted;

    logic [31:0] imem [32];
    logic [31:0] dmem [32];
    logic [31:0] s_imem [4];
    logic [31:0] m_dmem [32];
    logic [4:0]  we_addr_q [$];
    logic [31:0] we_data_q [$];
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          m_retired, m_cycles;

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } vec_t;
    vec_t vecs [14];

    always #5 clock = ~clock;

    multicycle_core dut (
        .CLOCK_50(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .halted(halted), .retired(retired)
    );

    multicycle_core #(.IMEM_AW(2), .DMEM_AW(5)) dut_small (
        .CLOCK_50(clock), .reset(s_reset), .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
        .dmem_addr(s_dmem_addr), .dmem_wdata(s_dmem_wdata), .dmem_we(s_dmem_we),
        .dmem_rdata(s_dmem_rdata), .halted(s_halted), .retired(s_retired)
    );

    assign s_dmem_rdata = 32'h0;

    // Synchronous ROM/RAM models with one cycle of read latency, plus a log of every write strobe cycle.
    always @(posedge clock) begin
        imem_rdata   <= imem[imem_addr];
        s_imem_rdata <= s_imem[s_imem_addr];
        dmem_rdata   <= dmem[dmem_addr];
        if (dmem_we === 1'b1) begin
            dmem[dmem_addr] <= dmem_wdata;
            we_addr_q.push_back(dmem_addr);
            we_data_q.push_back(dmem_wdata);
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clear_mem(input logic [31:0] fill);
        for (int i = 0; i < 32; i++) begin
            imem[i] = ECALL;
            dmem[i] = fill;
        end
    endtask

    // Hold reset across two edges, check the reset state mid-reset, release on a falling edge.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("rst_halted", {31'd0, halted}, 32'd0);
        check_output("rst_retired", retired, 32'd0);
        check_output("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check_output("rst_pc", {27'd0, imem_addr}, 32'd0);
        we_addr_q.delete();
        we_data_q.delete();
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input int max_cycles, output int cycles);
        cycles = 0;
        while (halted !== 1'b1 && cycles < max_cycles) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    // Instruction-level model: executes the program in imem against m_dmem, counting cycles per instruction class.
    task automatic ref_run();
        logic [31:0] x [32];
        logic [31:0] ins, a, b, r, addr;
        int          pc;
        for (int i = 0; i < 32; i++) x[i] = 32'd0;
        pc = 0;
        m_retired = 0;
        m_cycles = 0;
        for (int step = 0; step < 100; step++) begin
            ins = imem[pc];
            a = x[ins[19:15]];
            b = x[ins[24:20]];
            if (ins[6:0] == 7'b1110011) begin
                m_cycles += 2;
                break;
            end
            if (ins[6:0] == 7'b0010011 || ins[6:0] == 7'b0000011) b = {{20{ins[31]}}, ins[31:20]};
            r = 32'd0;
            case (ins[14:12])
                3'b000: r = (ins[6:0] == 7'b0110011 && ins[30]) ? a - b : a + b;
                3'b111: r = a & b;
                3'b110: r = a | b;
                3'b100: r = a ^ b;
                3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: r = 32'd0;
            endcase
            case (ins[6:0])
                7'b0110011, 7'b0010011: begin
                    x[ins[11:7]] = r;
                    m_cycles += 4;
                end
                7'b0000011: begin
                    addr = ((a + b) / 4) % 32;
                    x[ins[11:7]] = m_dmem[addr];
                    m_cycles += 5;
                end
                7'b0100011: begin
                    addr = ((a + {{20{ins[31]}}, ins[31:25], ins[11:7]}) / 4) % 32;
                    m_dmem[addr] = b;
                    m_cycles += 5;
                end
                default: m_cycles += 4;
            endcase
            x[0] = 32'd0;
            m_retired++;
            pc = (pc + 1) % 32;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        int          kind;
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        imm  = 12'($urandom());
        kind = $urandom_range(0, 13);
        case (kind % 5)
            0: f3 = 3'b000;
            1: f3 = 3'b111;
            2: f3 = 3'b110;
            3: f3 = 3'b100;
            default: f3 = 3'b010;
        endcase
        if (kind <= 4) return enc_r(7'b0000000, rs2, rs1, f3, rd);
        if (kind == 5) return enc_r(7'b0100000, rs2, rs1, 3'b000, rd);
        if (kind <= 10) return enc_i(imm, rs1, f3, rd, 7'b0010011);
        if (kind == 11) return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
        if (kind == 12) return enc_s(imm, rs2, rs1);
        return {25'($urandom()), 7'b0110111};
    endfunction

    initial begin
        int cycles;
        bit seen;
        logic [31:0] exp_pc;

        reset = 1'b1;
        s_reset = 1'b1;
        for (int i = 0; i < 4; i++) s_imem[i] = enc_i(12'h001, 5'd1, 3'b000, 5'd1, 7'b0010011);

        vecs[0]  = '{"add_ovf", enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vecs[1]  = '{"sub_neg", enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[2]  = '{"and",     enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        vecs[3]  = '{"or",      enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
        vecs[4]  = '{"xor",     enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
        vecs[5]  = '{"slt_t",   enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[6]  = '{"slt_f",   enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        vecs[7]  = '{"slt_min", enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
        vecs[8]  = '{"add_wrap",enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[9]  = '{"addi",    enc_i(12'hFFA, 5'd1, 3'b000, 5'd3, 7'b0010011), 32'h00000005, 32'h0, 32'hFFFFFFFF};
        vecs[10] = '{"andi",    enc_i(12'h0FF, 5'd1, 3'b111, 5'd3, 7'b0010011), 32'h12345678, 32'h0, 32'h00000078};
        vecs[11] = '{"ori",     enc_i(12'h800, 5'd1, 3'b110, 5'd3, 7'b0010011), 32'h12345600, 32'h0, 32'hFFFFFE00};
        vecs[12] = '{"xori",    enc_i(12'hFFF, 5'd1, 3'b100, 5'd3, 7'b0010011), 32'hAAAAAAAA, 32'h0, 32'h55555555};
        vecs[13] = '{"slti",    enc_i(12'h000, 5'd1, 3'b010, 5'd3, 7'b0010011), 32'h80000000, 32'h0, 32'h00000001};

        // Each vector: lw x1; lw x2; op x3; sw x3,8(x0); ecall -> 5+5+4+5+2 cycles.
        for (int v = 0; v < 14; v++) begin
            clear_mem(32'h0);
            dmem[0] = vecs[v].a;
            dmem[1] = vecs[v].b;
            imem[0] = enc_i(12'h000, 5'd0, 3'b010, 5'd1, 7'b0000011);
            imem[1] = enc_i(12'h004, 5'd0, 3'b010, 5'd2, 7'b0000011);
            imem[2] = vecs[v].instr;
            imem[3] = enc_s(12'h008, 5'd3, 5'd0);
            do_reset();
            apply_stimulus(100, cycles);
            check_output({vecs[v].name, "_result"}, dmem[2], vecs[v].expected);
            check_output({vecs[v].name, "_cycles"}, cycles, 32'd21);
        end

        // addi/addi/add/ecall: halt 14 cycles after release, then frozen.
        clear_mem(32'h0);
        imem[0] = enc_i(12'h005, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[1] = enc_i(12'h007, 5'd0, 3'b000, 5'd2, 7'b0010011);
        imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        do_reset();
        apply_stimulus(100, cycles);
        check_output("seq_halt_cycles", cycles, 32'd14);
        check_output("seq_halted", {31'd0, halted}, 32'd1);
        check_output("seq_retired", retired, 32'd3);
        repeat (6) @(posedge clock);
        #1;
        check_output("halt_retired_frozen", retired, 32'd3);
        check_output("halt_pc_frozen", {27'd0, imem_addr}, 32'd3);
        check_output("halt_we_low", {31'd0, dmem_we}, 32'd0);
        imem[3] = enc_s(12'h000, 5'd3, 5'd0);
        imem[4] = ECALL;
        do_reset();
        apply_stimulus(100, cycles);
        check_output("seq_x3", dmem[0], 32'd12);
        check_output("seq_x3_cycles", cycles, 32'd19);

        // Store then load of -1 at byte address 4; a second store exposes x3.
        clear_mem(32'h0);
        imem[0] = enc_i(12'h004, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[1] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd2, 7'b0010011);
        imem[2] = enc_s(12'h000, 5'd2, 5'd1);
        imem[3] = enc_i(12'h000, 5'd1, 3'b010, 5'd3, 7'b0000011);
        imem[4] = enc_s(12'h00C, 5'd3, 5'd0);
        do_reset();
        apply_stimulus(100, cycles);
        check_output("sw_we_cycles", we_addr_q.size(), 32'd2);
        if (we_addr_q.size() > 0) begin
            check_output("sw_addr", {27'd0, we_addr_q[0]}, 32'd1);
            check_output("sw_wdata", we_data_q[0], 32'hFFFFFFFF);
        end
        check_output("lw_x3", dmem[3], 32'hFFFFFFFF);

        // x0 stays zero.
        clear_mem(32'hDEADBEEF);
        imem[0] = enc_i(12'h009, 5'd0, 3'b000, 5'd0, 7'b0010011);
        imem[1] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd4);
        imem[2] = enc_s(12'h000, 5'd0, 5'd0);
        imem[3] = enc_s(12'h004, 5'd4, 5'd0);
        do_reset();
        apply_stimulus(100, cycles);
        check_output("x0_zero", dmem[0], 32'd0);
        check_output("x4_zero", dmem[1], 32'd0);

        // Reset while the store is in MEM must abort it, then the program reruns cleanly.
        clear_mem(32'h11111111);
        imem[0] = enc_i(12'h004, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[1] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd2, 7'b0010011);
        imem[2] = enc_s(12'h000, 5'd2, 5'd1);
        do_reset();
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clock);
            if (dmem_we === 1'b1) seen = 1'b1;
        end
        check_output("abort_we_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        check_output("abort_we_drop", {31'd0, dmem_we}, 32'd0);
        check_output("abort_pc", {27'd0, imem_addr}, 32'd0);
        check_output("abort_retired", retired, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check_output("abort_no_write", dmem[1], 32'h11111111);
        reset = 1'b0;
        apply_stimulus(100, cycles);
        check_output("abort_rerun_cycles", cycles, 32'd15);
        check_output("abort_rerun_mem", dmem[1], 32'hFFFFFFFF);
        check_output("abort_rerun_retired", retired, 32'd3);

        // Opcode 1100011 at PC=3: taken beq with the branch build, no-op otherwise; bne x0,x0 never taken.
`ifdef MULTICYCLE_CORE_BRANCH_EN
        exp_pc = 32'd2;
`else
        exp_pc = 32'd4;
`endif
        for (int k = 0; k < 2; k++) begin
            clear_mem(32'h0);
            imem[0] = NOP;
            imem[1] = NOP;
            imem[2] = NOP;
            imem[3] = enc_b(13'h1FFC, 5'd0, 5'd0, (k == 0) ? 3'b000 : 3'b001);
            do_reset();
            repeat (16) @(posedge clock);
            #1;
            check_output((k == 0) ? "beq_next_pc" : "bne_next_pc", {27'd0, imem_addr}, (k == 0) ? exp_pc : 32'd4);
            check_output((k == 0) ? "beq_retired" : "bne_retired", retired, 32'd4);
        end

        // PC wrap on a 4-word instruction memory.
        @(negedge clock);
        check_output("small_rst_retired", s_retired, 32'd0);
        s_reset = 1'b0;
        repeat (32) @(posedge clock);
        #1;
        check_output("wrap_retired", s_retired, 32'd8);
        check_output("wrap_pc", {30'd0, s_imem_addr}, 32'd0);
        check_output("wrap_x1", dut_small.regs[1], 32'd8);

        // Random programs, finished by dumping x1..x7 to dmem[0..6].
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 32; i++) begin
                dmem[i]   = $urandom();
                m_dmem[i] = dmem[i];
            end
            for (int i = 0; i < 24; i++) imem[i] = rand_instr();
            for (int i = 24; i < 31; i++) imem[i] = enc_s(12'(4 * (i - 24)), 5'(i - 23), 5'd0);
            imem[31] = ECALL;
            ref_run();
            do_reset();
            apply_stimulus(400, cycles);
            check_output("rand_halted", {31'd0, halted}, 32'd1);
            check_output("rand_cycles", cycles, m_cycles);
            check_output("rand_retired", retired, m_retired);
            for (int i = 0; i < 32; i++) check_output($sformatf("rand%0d_dmem%0d", run, i), dmem[i], m_dmem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter IMEM_AW, default 5: instruction memory word-address width; PC width.
REQ-002 Parameter DMEM_AW, default 5: data memory word-address width.
REQ-003 CLOCK_50  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 imem_addr  output  IMEM_AW: instruction word address (equals PC).
REQ-006 imem_rdata  input  32: instruction word, valid 1 cycle after imem_addr (synchronous ROM).
REQ-007 dmem_addr  output  DMEM_AW: data word address = alu_res[DMEM_AW+1:2].
REQ-008 dmem_wdata  output  32: store data = rs2 value.
REQ-009 dmem_we  output  1: data memory write strobe.
REQ-010 dmem_rdata  input  32: load data, valid 1 cycle after dmem_addr (synchronous RAM).
REQ-011 halted  output  1: high while in HALT.
REQ-012 retired  output  32: count of completed instructions.

Function
REQ-013 The block SHALL be a multi-cycle RV32I subset core with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 Supported: add, sub, and, or, xor, slt (opcode 0110011); addi, andi, ori, xori, slti (0010011); lw (0000011); sw (0100011); ecall (1110011) = halt.
REQ-015 Any other opcode SHALL execute as a no-op: no register or memory write; PC+1; retired+1.
REQ-016 FETCH: drive imem_addr=PC; next DECODE.
REQ-017 DECODE: latch imem_rdata into IR; read rs1=IR[19:15], rs2=IR[24:20]; next EXEC, or HALT if opcode is 1110011.
REQ-018 EXEC: alu_res = rs1 op (rs2 for R-type, sext(IR[31:20]) for I-type/load, sext({IR[31:25],IR[11:7]}) for store); next MEM for lw/sw, otherwise WB.
REQ-019 MEM: drive dmem_addr; dmem_we=1 for exactly this one cycle on sw only; next WB.
REQ-020 WB: write rd=IR[11:7] with dmem_rdata (lw) or alu_res (R/I-type); PC <= next PC; retired+1; next FETCH.
REQ-021 Latency: R/I-type and no-op 4 cycles; lw/sw 5 cycles; branches 4 cycles.
REQ-022 Register file: 32 x 32 bits, internal; x0 reads 0 and writes to it are discarded.
REQ-023 Arithmetic is 32-bit modulo 2^32; slt/slti compare signed.
REQ-024 PC is a word index of IMEM_AW bits and SHALL wrap from 2^IMEM_AW-1 to 0.
REQ-025 dmem_addr bits above DMEM_AW+1 SHALL be ignored (address aliasing, no fault).
REQ-026 HALT is terminal until reset: no fetch, dmem_we=0, retired frozen, halted=1.
REQ-027 retired SHALL wrap from 2^32-1 to 0.
REQ-028 dmem_we SHALL be 0 in every state except MEM of a store.

Reset
REQ-029 While reset=1: state=FETCH, PC=0, IR=0, retired=0, halted=0, dmem_we=0, all registers=0.
REQ-030 Reset asserted mid-instruction SHALL abort it with no register write and no further memory write; after release, fetch restarts at PC=0 on the next rising edge.

Configuration
REQ-031 Macro MULTICYCLE_CORE_BRANCH_EN: when defined, beq/bne (opcode 1100011, funct3 000/001) are supported: compare in EXEC; in WB, if taken PC <= PC + (sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}) >>> 2), else PC+1; no register write.
REQ-032 When MULTICYCLE_CORE_BRANCH_EN is not defined, opcode 1100011 SHALL execute as a no-op per REQ-015.

Verification
REQ-033 addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; ecall -> x3=12, retired=3, halted=1, halt entered 14 cycles after reset release.
REQ-034 addi x1,x0,4; addi x2,x0,-1; sw x2,0(x1); lw x3,0(x1) -> one dmem_we pulse at dmem_addr=1 with wdata 0xFFFFFFFF; x3=0xFFFFFFFF.
REQ-035 addi x0,x0,9; add x4,x0,x0 -> x0 and x4 read 0.
REQ-036 IMEM_AW=2, four addi x1,x1,1 and no ecall -> PC wraps to 0; retired=8 and x1=8 after 32 cycles.
REQ-037 Assert reset during MEM of sw -> dmem_we drops immediately; PC=0, retired=0; program re-executes correctly.
REQ-038 With MULTICYCLE_CORE_BRANCH_EN: beq x0,x0,-4 at PC=3 -> next PC=2; without the macro -> next PC=4, retired+1.
